mor1kx_pipeline_adv_ctrl_cappuccino: RTL and testbench

Central advance/flush sequencer for the cappuccino pipeline. Generates the per-stage advance strobes (padv_decode, padv_execute, padv_ctrl) that the execute→ctrl stage register consumes. Folds in execute-stage waiting, exception/rfe flushes and debug-unit stalls, and marks bubbles entering ctrl. Sits in the cappuccino top level between fetch/decode, execute_ctrl and ctrl.

---
 rtl/mor1kx_pipeline_adv_ctrl_cappuccino_pkg.sv | 11 +
 rtl/mor1kx_pipeline_adv_ctrl_cappuccino_perf_counter.sv | 14 +
 rtl/mor1kx_pipeline_adv_ctrl_cappuccino.sv | 97 +++++++++
 tb/tb_mor1kx_pipeline_adv_ctrl_cappuccino.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/mor1kx_pipeline_adv_ctrl_cappuccino_pkg.sv
// mor1kx_pipeline_adv_ctrl_cappuccino_pkg: state encodings and hold limits for the pipeline advance sequencer
package mor1kx_pipeline_adv_ctrl_cappuccino_pkg;
    typedef enum logic [1:0] {
        PIPE_ST_RUN     = 2'd0,
        PIPE_ST_FLUSH   = 2'd1,
        PIPE_ST_HOLD    = 2'd2,
        PIPE_ST_DU_HALT = 2'd3
    } pipe_state_t;
    localparam int PIPE_HOLD_MAX = 15;
    localparam int PIPE_HOLD_W = $clog2(PIPE_HOLD_MAX + 1);
endpackage

// File: rtl/mor1kx_pipeline_adv_ctrl_cappuccino_perf_counter.sv
// mor1kx_pipe_perf_counter: enable-gated counter that wraps modulo 2^W
module mor1kx_pipe_perf_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] cnt
);
    // count one per enabled cycle, wrapping naturally
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (en) cnt <= cnt + W'(1);
endmodule

// File: rtl/mor1kx_pipeline_adv_ctrl_cappuccino.sv
// mor1kx_pipeline_adv_ctrl_cappuccino: pipeline advance/flush sequencer; MOR1KX_PIPE_PERF_CNT_EN adds stall/bubble counters
module mor1kx_pipeline_adv_ctrl_cappuccino
    import mor1kx_pipeline_adv_ctrl_cappuccino_pkg::*;
#(
    parameter int FLUSH_HOLD_CYCLES = 2,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 decode_valid_i,
    input  logic                 decode_bubble_i,
    input  logic                 execute_valid_i,
    input  logic                 except_req_i,
    input  logic                 op_rfe_ctrl_i,
    input  logic                 du_stall_i,
    output logic                 padv_decode_o,
    output logic                 padv_execute_o,
    output logic                 padv_ctrl_o,
    output logic                 execute_bubble_o,
    output logic                 pipeline_flush_o,
    output logic                 du_stall_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o,
    output logic [CNT_WIDTH-1:0] bubble_cnt_o
);
    localparam logic [PIPE_HOLD_W-1:0] HOLD_LOAD = PIPE_HOLD_W'(FLUSH_HOLD_CYCLES - 1);

    pipe_state_t            state, state_nxt;
    logic [PIPE_HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
    logic                   run;

    // state and hold counter registers
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state    <= PIPE_ST_RUN;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
        end

    // next state: flush beats debug stall; both only sampled once ctrl completes
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        case (state)
            PIPE_ST_RUN:
                if (execute_valid_i) begin
                    if (except_req_i | op_rfe_ctrl_i) state_nxt = PIPE_ST_FLUSH;
                    else if (du_stall_i) state_nxt = PIPE_ST_DU_HALT;
                end
            PIPE_ST_FLUSH: begin
                state_nxt    = PIPE_ST_HOLD;
                hold_cnt_nxt = HOLD_LOAD;
            end
            PIPE_ST_HOLD:
                if (hold_cnt <= PIPE_HOLD_W'(1)) begin
                    state_nxt    = PIPE_ST_RUN;
                    hold_cnt_nxt = '0;
                end else begin
                    hold_cnt_nxt = hold_cnt - PIPE_HOLD_W'(1);
                end
            PIPE_ST_DU_HALT:
                if (!du_stall_i) begin
                    state_nxt    = PIPE_ST_HOLD;
                    hold_cnt_nxt = HOLD_LOAD;
                end
            default: state_nxt = PIPE_ST_RUN;
        endcase
    end

    // advance strobes are gated by reset so every output reads 0 while rst_n is low
    assign run              = rst_n & (state == PIPE_ST_RUN);
    assign padv_ctrl_o      = run & execute_valid_i;
    assign padv_execute_o   = run & execute_valid_i;
    assign padv_decode_o    = run & execute_valid_i & decode_valid_i;
    assign execute_bubble_o = padv_execute_o & (!decode_valid_i | decode_bubble_i);
    assign pipeline_flush_o = (state == PIPE_ST_FLUSH) | (state == PIPE_ST_DU_HALT);
    assign du_stall_o       = (state == PIPE_ST_DU_HALT);

`ifdef MOR1KX_PIPE_PERF_CNT_EN
    mor1kx_pipe_perf_counter #(.W(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (run & !execute_valid_i),
        .cnt   (stall_cnt_o)
    );
    mor1kx_pipe_perf_counter #(.W(CNT_WIDTH)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (execute_bubble_o),
        .cnt   (bubble_cnt_o)
    );
`else
    assign stall_cnt_o  = '0;
    assign bubble_cnt_o = '0;
`endif
endmodule

// File: tb/tb_mor1kx_pipeline_adv_ctrl_cappuccino.sv
// tb_mor1kx_pipeline_adv_ctrl_cappuccino: random stimulus against a blackout-window reference model
module tb_mor1kx_pipeline_adv_ctrl_cappuccino;
    localparam int H = 2;
    localparam int CW = 32;

    logic clk = 0, rst_n = 0;
    logic decode_valid_i = 0, decode_bubble_i = 0, execute_valid_i = 0;
    logic except_req_i = 0, op_rfe_ctrl_i = 0, du_stall_i = 0;
    logic padv_decode_o, padv_execute_o, padv_ctrl_o, execute_bubble_o;
    logic pipeline_flush_o, du_stall_o;
    logic [CW-1:0] stall_cnt_o, bubble_cnt_o;

    int n_checks = 0, n_fail = 0;

    bit          m_halted, m_flush_now;
    int          m_blackout;
    logic [CW-1:0] m_stall, m_bubble;

    mor1kx_pipeline_adv_ctrl_cappuccino #(.FLUSH_HOLD_CYCLES(H), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .decode_valid_i(decode_valid_i), .decode_bubble_i(decode_bubble_i),
        .execute_valid_i(execute_valid_i), .except_req_i(except_req_i),
        .op_rfe_ctrl_i(op_rfe_ctrl_i), .du_stall_i(du_stall_i),
        .padv_decode_o(padv_decode_o), .padv_execute_o(padv_execute_o),
        .padv_ctrl_o(padv_ctrl_o), .execute_bubble_o(execute_bubble_o),
        .pipeline_flush_o(pipeline_flush_o), .du_stall_o(du_stall_o),
        .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int hold_len();
        return (H - 1 < 1) ? 1 : H - 1;
    endfunction

    function automatic bit m_running();
        return !m_halted && !m_flush_now && m_blackout == 0;
    endfunction

    task automatic model_reset();
        m_halted = 0; m_flush_now = 0; m_blackout = 0; m_stall = '0; m_bubble = '0;
    endtask

    task automatic check_outputs();
        bit r;
        logic e_bub;
        r = m_running();
        e_bub = r & execute_valid_i & (!decode_valid_i | decode_bubble_i);
        check("padv_ctrl", padv_ctrl_o, r & execute_valid_i);
        check("padv_execute", padv_execute_o, r & execute_valid_i);
        check("padv_decode", padv_decode_o, r & execute_valid_i & decode_valid_i);
        check("execute_bubble", execute_bubble_o, e_bub);
        check("pipeline_flush", pipeline_flush_o, m_flush_now | m_halted);
        check("du_stall", du_stall_o, m_halted);
`ifdef MOR1KX_PIPE_PERF_CNT_EN
        check("stall_cnt", stall_cnt_o, m_stall);
        check("bubble_cnt", bubble_cnt_o, m_bubble);
`else
        check("stall_cnt", stall_cnt_o, 0);
        check("bubble_cnt", bubble_cnt_o, 0);
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"}, {padv_decode_o, padv_execute_o, padv_ctrl_o, execute_bubble_o,
                               pipeline_flush_o, du_stall_o}, 0);
        check({tag, "_stall_cnt"}, stall_cnt_o, 0);
        check({tag, "_bubble_cnt"}, bubble_cnt_o, 0);
    endtask

    task automatic model_advance();
        bit r;
        r = m_running();
        if (r && !execute_valid_i) m_stall++;
        if (r && execute_valid_i && (!decode_valid_i || decode_bubble_i)) m_bubble++;
        if (m_halted) begin
            if (!du_stall_i) begin m_halted = 0; m_blackout = hold_len(); end
        end else if (m_flush_now) begin
            m_flush_now = 0; m_blackout = hold_len();
        end else if (m_blackout > 0) begin
            m_blackout--;
        end else if (execute_valid_i) begin
            if (except_req_i || op_rfe_ctrl_i) m_flush_now = 1;
            else if (du_stall_i) m_halted = 1;
        end
    endtask

    task automatic step(input logic ev, dv, db, ex, rfe, du);
        @(negedge clk);
        execute_valid_i = ev; decode_valid_i = dv; decode_bubble_i = db;
        except_req_i = ex; op_rfe_ctrl_i = rfe; du_stall_i = du;
        #1 check_outputs();
        @(posedge clk);
        model_advance();
    endtask

    initial begin
        logic du;
        model_reset();
        execute_valid_i = 1; decode_valid_i = 1;
        #12 check_all_zero("reset");
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 0);
        du = 0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 9) == 0) du = ~du;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0, du);
        end
        for (int i = 0; i < 20 && !m_running(); i++) step(0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        @(negedge clk);
        execute_valid_i = 1; decode_valid_i = 1;
        #2 rst_n = 0;
        #1 check_all_zero("mid_hold_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
